// File: rtl/adder_pkg.sv
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared types and helpers for the adder sum accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } acc_state_t;

    // Width of a counter that must reach BLOCK_LEN inclusive.
    function automatic int count_width(input int block_len);
        return $clog2(block_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_sum_accumulator_add.sv
// ============================================================================
// Module   : acc_add_sat
// Purpose  : Combinational ACC_WIDTH adder with carry flag; wraps by default,
//            clamps to all-ones when ACC_SATURATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_add_sat #(
    parameter int ACC_WIDTH = 12
) (
    input  logic [ACC_WIDTH-1:0] i_a,
    input  logic [ACC_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_carry
);

    logic [ACC_WIDTH:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[ACC_WIDTH];

`ifdef ACC_SATURATE_EN
    // Once clamped, any further non-zero sample carries again, so it stays clamped.
    assign o_sum = o_carry ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];
`else
    assign o_sum = w_full[ACC_WIDTH-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/adder_sum_accumulator.sv
// ============================================================================
// Module   : adder_sum_accumulator
// Purpose  : Accumulates BLOCK_LEN {cout,sum} samples and presents the block
//            total over valid/ready. Optional macro: ACC_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_sum_accumulator
    import adder_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12,
    parameter int BLOCK_LEN = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                in_valid,
    input  logic [WIDTH-1:0]                    in_sum,
    input  logic                                in_cout,
    output logic                                in_ready,
    input  logic                                out_ready,
    output logic [ACC_WIDTH-1:0]                acc_out,
    output logic                                acc_valid,
    output logic [$clog2(BLOCK_LEN+1)-1:0]      count,
    output logic                                overflow
);

    localparam int CNT_W = count_width(BLOCK_LEN);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(BLOCK_LEN - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    acc_state_t             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]   w_sample;
    logic [ACC_WIDTH-1:0]   w_add_sum;
    logic                   w_add_carry;

    assign w_sample = ACC_WIDTH'({in_cout, in_sum});

    acc_add_sat #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .i_a     (acc_q),
        .i_b     (w_sample),
        .o_sum   (w_add_sum),
        .o_carry (w_add_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // First sample is WIDTH+1 bits wide and cannot overflow the load.
                    if (in_valid) begin
                        acc_d   = w_sample;
                        count_d = C_ONE;
                        ovf_d   = 1'b0;
                        state_d = (BLOCK_LEN == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_d   = w_add_sum;
                        count_d = count_q + C_ONE;
                        ovf_d   = ovf_q | w_add_carry;
                        if (count_q == C_LAST_IDX) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q != DONE);
    assign acc_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_sum_accumulator.sv
// ============================================================================
// Module   : tb_adder_sum_accumulator
// Purpose  : Scoreboard bench for adder_sum_accumulator (WIDTH=4, ACC_WIDTH=6,
//            BLOCK_LEN=4); honours ACC_SATURATE_EN in its reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_sum_accumulator;

    localparam int WIDTH     = 4;
    localparam int ACC_WIDTH = 6;
    localparam int BLOCK_LEN = 4;
    localparam int CNT_W     = $clog2(BLOCK_LEN + 1);
    localparam int ACC_MAX   = (1 << ACC_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_sum;
    logic                 in_cout;
    logic                 in_ready;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] acc_out;
    logic                 acc_valid;
    logic [CNT_W-1:0]     count;
    logic                 overflow;

    adder_sum_accumulator #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .BLOCK_LEN (BLOCK_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        bit ovf;
    } total_t;

    total_t exp_q[$];

    // Reference model: plain list-of-samples semantics kept as a true integer sum.
    int  m_sum  = 0;
    int  m_n    = 0;
    bit  m_done = 1'b0;

    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;
    bit  prev_valid = 1'b0;
    total_t held;

    function automatic int model_acc(input int s);
`ifdef ACC_SATURATE_EN
        return (s > ACC_MAX) ? ACC_MAX : s;
`else
        return s % (ACC_MAX + 1);
`endif
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input logic v, input int val, input logic ordy,
                        input logic clr, input logic rn);
        total_t t;
        in_valid  = v;
        {in_cout, in_sum} = 5'(val);
        out_ready = ordy;
        clear     = clr;
        rst       = rn;
        @(posedge clk);
        if (!rn || clr) begin
            m_sum = 0; m_n = 0; m_done = 1'b0;
        end else if (m_done) begin
            if (ordy) begin
                m_sum = 0; m_n = 0; m_done = 1'b0;
            end
        end else if (v) begin
            m_sum += val;
            m_n++;
            if (m_n == BLOCK_LEN) begin
                m_done = 1'b1;
                t.acc  = model_acc(m_sum);
                t.ovf  = (m_sum > ACC_MAX);
                exp_q.push_back(t);
            end
        end
        #1;
    endtask

    task automatic block(input int a, input int b, input int c, input int d);
        step(1'b1, a, 1'b0, 1'b0, 1'b1);
        step(1'b1, b, 1'b0, 1'b0, 1'b1);
        step(1'b1, c, 1'b0, 1'b0, 1'b1);
        step(1'b1, d, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: per-cycle visible state plus scoreboard pop on each new total.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready",  int'(in_ready),  int'(!m_done));
            check("acc_valid", int'(acc_valid), int'(m_done));
            check("count",     int'(count),     m_n);
            check("acc_out",   int'(acc_out),   model_acc(m_sum));
            check("overflow",  int'(overflow),  int'(m_sum > ACC_MAX));
            if (acc_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_total", 1, 0);
                end else begin
                    held = exp_q.pop_front();
                    check("total_acc", int'(acc_out),  held.acc);
                    check("total_ovf", int'(overflow), int'(held.ovf));
                end
            end else if (acc_valid) begin
                check("held_acc", int'(acc_out), held.acc);
            end
            prev_valid = acc_valid;
        end
    end

    initial begin
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Basic block: 50
        block(17, 18, 10, 5);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Bubbles then backpressure with in_valid held high
        step(1'b1, 1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9, 1'b1, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Overflow: 4 x 31
        block(31, 31, 31, 31);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);

        // Clear mid-block drops the concurrent sample
        step(1'b1, 7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5, 1'b0, 1'b1, 1'b1);
        block(1, 1, 1, 1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);

        // Reset mid-block
        step(1'b1, 20, 1'b0, 1'b0, 1'b1);
        step(1'b1, 20, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3, 1'b1, 1'b0, 1'b0);
        block(2, 2, 2, 2);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);

        // Clear while a total is pending
        block(3, 3, 3, 3);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 6, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'b1 & ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 31)),
                 1'b1 & ($urandom_range(0, 2) != 0),
                 1'b1 & ($urandom_range(0, 40) == 0),
                 1'b1 & ($urandom_range(0, 80) != 0));
        end
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        mon_en = 1'b0;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
